// File: rtl/stack_pkg.sv
// Shared types and width helpers for the parametrised placement stack.
package stack_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam int PLACEMENT_W = 6;

  // Default entry layout: {row[2:0], col[2:0]}
  localparam int ROW_MSB = 5;
  localparam int ROW_LSB = 3;
  localparam int COL_MSB = 2;
  localparam int COL_LSB = 0;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, two combinational read ports.
module stack_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_top_addr,
  input  logic [AW-1:0]    i_peek_addr,
  output logic [WIDTH-1:0] o_top_data,
  output logic [WIDTH-1:0] o_peek_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_top_data  = r_mem[i_top_addr];
  assign o_peek_data = r_mem[i_peek_addr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO for the backtracking solver: push, pop, replace-top, peek, multi-cycle clear.
// Optional high-water output enabled by defining PARAM_STACK_HIGH_WATER_EN.
module param_stack
  import stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PLACEMENT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   user_push,
  input  logic                   user_pop,
  input  logic                   user_clear,
  input  logic [WIDTH-1:0]       bus_in,
  output logic [WIDTH-1:0]       bus_out,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [WIDTH-1:0]       peek_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   ready
`ifdef PARAM_STACK_HIGH_WATER_EN
  ,
  output logic [$clog2(DEPTH):0] high_water
`endif
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  state_t           r_state;
  logic [AW-1:0]    r_clr_addr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_udf;
  logic             r_ready;

  logic             w_idle, w_full, w_empty, w_req_ok;
  logic             w_push_new, w_replace, w_pop, w_ovf, w_udf;
  logic [AW-1:0]    w_top_addr, w_peek_addr;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata, w_top_data, w_peek_data;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A clear request swallows any simultaneous push/pop, including their flags.
  assign w_req_ok = w_idle & ~user_clear;

  assign w_push_new = w_req_ok & user_push & (user_pop ? w_empty : ~w_full);
  assign w_replace  = w_req_ok & user_push & user_pop & ~w_empty;
  assign w_pop      = w_req_ok & user_pop & ~user_push & ~w_empty;
  assign w_ovf      = w_req_ok & user_push & ~user_pop & w_full;
  assign w_udf      = w_req_ok & user_pop & w_empty;

  // At count==DEPTH the low bits wrap to 0, so top-1 lands on DEPTH-1 as required.
  assign w_top_addr  = r_count[AW-1:0] - AW'(1);
  assign w_peek_addr = w_top_addr - peek_idx;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_count[AW-1:0];
    w_wdata = bus_in;
    if (!w_idle) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = '0;
    end else if (w_push_new) begin
      w_we    = 1'b1;
    end else if (w_replace) begin
      w_we    = 1'b1;
      w_waddr = w_top_addr;
    end
  end

  stack_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk         (clk),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_top_addr  (w_top_addr),
    .i_peek_addr (w_peek_addr),
    .o_top_data  (w_top_data),
    .o_peek_data (w_peek_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_clr_addr <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_ovf <= w_ovf;
      r_udf <= w_udf;
      case (r_state)
        ST_IDLE: begin
          if (user_clear) begin
            r_count    <= '0;
            r_clr_addr <= '0;
            r_state    <= ST_CLEAR;
            r_ready    <= 1'b0;
          end else if (w_push_new) begin
            r_count <= r_count + CW'(1);
          end else if (w_pop) begin
            r_count <= r_count - CW'(1);
          end
        end
        ST_CLEAR: begin
          if (r_clr_addr == AW'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PARAM_STACK_HIGH_WATER_EN
  logic [CW-1:0] r_hw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_hw <= '0;
    else if (w_idle && user_clear) r_hw <= '0;
    else if (r_count > r_hw)       r_hw <= r_count;
  end

  assign high_water = r_hw;
`endif

  assign bus_out   = w_empty ? '0 : w_top_data;
  assign peek_data = ({1'b0, peek_idx} < r_count) ? w_peek_data : '0;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_udf;
  assign ready     = r_ready;

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO for the 8-queen backtracking datapath: holds (row, col) placements and serves push, pop, replace-top and random peek.
- Successor to the fixed 8x6 stack. Generalised in DEPTH and WIDTH.
- Adds occupancy count, indexed peek, combined push+pop (replace top), and a multi-cycle clear sequence gated by ready.
- Sits between the solver controller FSM and the placement checker.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
WIDTH, 6, entry width in bits (default {row[2:0], col[2:0]})

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
user_push  in  1  push request; sampled only when ready=1
user_pop  in  1  pop request; sampled only when ready=1
user_clear  in  1  start clear sequence; sampled only when ready=1
bus_in  in  WIDTH  data to push
bus_out  out  WIDTH  current top of stack; 0 when empty
peek_idx  in  $clog2(DEPTH)  depth index below top (0 = top)
peek_data  out  WIDTH  entry at top-peek_idx; 0 if peek_idx >= count
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  one-cycle pulse: rejected push
underflow  out  1  one-cycle pulse: rejected pop
ready  out  1  block accepts requests

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, pointer=0, state=IDLE.
  - ready=1, overflow=0, underflow=0.
  - Memory contents undefined; bus_out and peek_data read 0 because count=0.
- States:
  - IDLE (ready=1)
  - CLEAR (ready=0; walks addresses 0..DEPTH-1 writing zeros, one per cycle)
- Request priority in IDLE, all effects visible the cycle after the sampling edge:
  - user_clear: count<=0, enter CLEAR. Any push/pop in the same cycle is ignored and raises no flags.
  - push only, not full: mem[count]<=bus_in, count+1.
  - push only, full: no change, overflow pulses 1 cycle.
  - pop only, not empty: count-1. Popped value is the bus_out seen before the edge.
  - pop only, empty: no change, underflow pulses 1 cycle.
  - push+pop, not empty: replace top (mem[count-1]<=bus_in), count unchanged, no flags. Full is legal here.
  - push+pop, empty: push performed (count=1), underflow pulses.
- CLEAR:
  - Lasts exactly DEPTH cycles, then returns to IDLE; ready=1 in the following cycle.
  - Requests are ignored and raise no flags.
  - Reset mid-CLEAR aborts to IDLE immediately.
- bus_out and peek_data are combinational reads of registered memory/count.
- Flags are registered. Overflow and underflow never assert in the same cycle.
- Counter arithmetic is WIDTH-independent. count never wraps; saturation is via the reject rules above.

Optional Feature:
- Macro: PARAM_STACK_HIGH_WATER_EN.
- When defined:
  - Adds output high_water [$clog2(DEPTH)+1], the maximum count since reset or clear.
  - Updates the cycle after count changes.
  - Reset and clear set it to 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package stack_pkg:
  - State enum (ST_IDLE, ST_CLEAR).
  - Default PLACEMENT_W=6 and localparam helpers for count/index widths.
  - Row/col field slice constants.
- One sub-module, stack_mem: DEPTH x WIDTH register array with one write port and two combinational read ports (top, peek).
- Control FSM and counter stay in param_stack.

Test Plan:
1. Reset, then push 0x00, 0x0E, 0x15: count=3, bus_out=0x15, peek_idx=2 gives peek_data=0x00, empty=0, full=0.
2. Push 8 values into DEPTH=8, then push again: full=1, count=8, overflow high exactly one cycle, top unchanged.
3. Empty stack, pop: underflow one cycle, count=0, bus_out=0. Then push+pop with bus_in=0x09: count=1, bus_out=0x09, underflow one cycle.
4. Count=3, push+pop with bus_in=0x2A: count=3, bus_out=0x2A, no flags. Repeat at full: count=8, no overflow.
5. Count=5, assert clear together with push:
   - ready=0 for 8 cycles, count=0 from the next cycle.
   - Pushes during CLEAR ignored with no flags.
   - ready=1 afterwards.
6. Drop reset mid-CLEAR (cycle 3): ready=1 and count=0 immediately. With PARAM_STACK_HIGH_WATER_EN: push 4, pop 2 gives high_water=4; clear gives 0.
